// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants for the MEM->WB elastic pipeline.
//   RST_ACTIVE   : level of rst that holds the block in reset (active-low)
//   ZERO_BIT     : fill bit used to build all-zero data words
//   NOP_REG_ADDR : destination register address presented when no entry is held
//   WREG_EN/DIS  : write-enable encodings for wb_wreg / wb_whilo
package mem_wb_pipe_pkg;
   localparam logic RST_ACTIVE   = 1'b0;
   localparam logic ZERO_BIT     = 1'b0;
   localparam int   NOP_REG_ADDR = 0;
   localparam logic WREG_EN      = 1'b1;
   localparam logic WREG_DIS     = 1'b0;
endpackage

// File: rtl/mem_wb_stage.sv
// One elastic register stage of the MEM->WB pipeline.
// Holds a valid bit and an opaque payload. When the stage is allowed to load,
// it takes whatever the upstream side presents; an empty load parks the
// payload at EMPTY so downstream outputs never show stale data.
// Ports:
//   clk, rst        : clock, async active-low reset
//   flush           : synchronous discard of the held entry
//   load            : stage may take a new value this edge
//   in_valid/in_data: upstream entry
//   valid/data      : held entry
module mem_wb_stage
   import mem_wb_pipe_pkg::*;
#(
   parameter int             W     = 38,
   parameter logic [W-1:0]   EMPTY = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         load,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         valid,
   output logic [W-1:0] data
);

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         valid <= 1'b0;
         data  <= EMPTY;
      end else if (flush) begin
         valid <= 1'b0;
         data  <= EMPTY;
      end else if (load) begin
         valid <= in_valid;
         data  <= in_valid ? in_data : EMPTY;
      end
   end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB elastic pipeline with DEPTH (1..4) register stages.
// Entries move one stage per cycle and close up behind any empty stage, so
// with wb_ready held high the latency is exactly DEPTH cycles at full rate.
// WB outputs come straight from the last stage register.
// Optional feature: define MEM_WB_HILO_EN to carry hi/lo/whilo alongside the
// register write-back through every stage.
// Ports:
//   clk, rst                      : clock, async active-low reset
//   mem_wdata, mem_wd, mem_wreg   : MEM-stage result, destination, write enable
//   mem_hi, mem_lo, mem_whilo     : (MEM_WB_HILO_EN) hi/lo result and enable
//   mem_valid / mem_ready         : upstream handshake
//   flush                         : discard all held entries
//   wb_wdata, wb_wd, wb_wreg      : WB-stage result
//   wb_hi, wb_lo, wb_whilo        : (MEM_WB_HILO_EN) WB hi/lo result
//   wb_valid / wb_ready           : downstream handshake
//   occupancy                     : number of valid entries held
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          mem_wdata,
   input  logic [ADDR_W-1:0]          mem_wd,
   input  logic                       mem_wreg,
`ifdef MEM_WB_HILO_EN
   input  logic [DATA_W-1:0]          mem_hi,
   input  logic [DATA_W-1:0]          mem_lo,
   input  logic                       mem_whilo,
`endif
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic                       flush,
   output logic [DATA_W-1:0]          wb_wdata,
   output logic [ADDR_W-1:0]          wb_wd,
   output logic                       wb_wreg,
`ifdef MEM_WB_HILO_EN
   output logic [DATA_W-1:0]          wb_hi,
   output logic [DATA_W-1:0]          wb_lo,
   output logic                       wb_whilo,
`endif
   output logic                       wb_valid,
   input  logic                       wb_ready,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

`ifdef MEM_WB_HILO_EN
   localparam int PW = 3*DATA_W + ADDR_W + 2;
   localparam logic [PW-1:0] EMPTY_PL = {{DATA_W{ZERO_BIT}}, ADDR_W'(NOP_REG_ADDR), WREG_DIS,
                                         {DATA_W{ZERO_BIT}}, {DATA_W{ZERO_BIT}}, WREG_DIS};
`else
   localparam int PW = DATA_W + ADDR_W + 1;
   localparam logic [PW-1:0] EMPTY_PL = {{DATA_W{ZERO_BIT}}, ADDR_W'(NOP_REG_ADDR), WREG_DIS};
`endif

   logic [PW-1:0]    mem_pl;
   logic [DEPTH-1:0] valid_s;
   logic [DEPTH-1:0] load_s;
   logic [PW-1:0]    data_s [DEPTH];
   logic [PW-1:0]    last_pl;
   logic             last_wreg;
   logic             in_xfer;
   logic             out_xfer;
   logic [OCC_W-1:0] occ;

`ifdef MEM_WB_HILO_EN
   logic last_whilo;
   assign mem_pl = {mem_wdata, mem_wd, mem_wreg, mem_hi, mem_lo, mem_whilo};
   assign {wb_wdata, wb_wd, last_wreg, wb_hi, wb_lo, last_whilo} = last_pl;
   assign wb_whilo = (wb_valid && last_whilo == WREG_EN) ? WREG_EN : WREG_DIS;
`else
   assign mem_pl = {mem_wdata, mem_wd, mem_wreg};
   assign {wb_wdata, wb_wd, last_wreg} = last_pl;
`endif

   assign last_pl  = data_s[DEPTH-1];
   assign wb_valid = valid_s[DEPTH-1];
   assign wb_wreg  = (wb_valid && last_wreg == WREG_EN) ? WREG_EN : WREG_DIS;

   // A stage may load when it is empty or its occupant moves on this edge.
   // Walking from the WB end keeps this a single forward-computed chain.
   always_comb begin : p_ready
      logic r;
      load_s = '0;
      r      = wb_ready;
      for (int k = DEPTH-1; k >= 0; k--) begin
         r         = !valid_s[k] || r;
         load_s[k] = r;
      end
   end

   assign mem_ready = load_s[0] && !flush;
   assign in_xfer   = mem_valid && mem_ready;
   assign out_xfer  = wb_valid && wb_ready;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic          in_v;
      logic [PW-1:0] in_d;
      if (k == 0) begin : g_first
         assign in_v = in_xfer;
         assign in_d = mem_pl;
      end else begin : g_next
         assign in_v = valid_s[k-1];
         assign in_d = data_s[k-1];
      end
      mem_wb_stage #(
         .W     (PW),
         .EMPTY (EMPTY_PL)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .load     (load_s[k]),
         .in_valid (in_v),
         .in_data  (in_d),
         .valid    (valid_s[k]),
         .data     (data_s[k])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         occ <= '0;
      end else if (flush) begin
         occ <= '0;
      end else if (in_xfer && !out_xfer) begin
         occ <= occ + OCC_W'(1);
      end else if (!in_xfer && out_xfer) begin
         occ <= occ - OCC_W'(1);
      end
   end

   assign occupancy = occ;

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning write-back data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning destination register address width.
REQ-003 SHALL have parameter DEPTH, default 1, legal range 1..4, meaning number of elastic register stages between MEM and WB.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports mem_wdata  input  DATA_W, mem_wd  input  ADDR_W, mem_wreg  input  1: MEM-stage result, destination, write enable.
REQ-007 SHALL have ports mem_valid  input  1 and mem_ready  output  1: upstream handshake.
REQ-008 SHALL have port flush  input  1: synchronous discard of all held entries.
REQ-009 SHALL have ports wb_wdata  output  DATA_W, wb_wd  output  ADDR_W, wb_wreg  output  1: WB-stage result.
REQ-010 SHALL have ports wb_valid  output  1 and wb_ready  input  1: downstream handshake.
REQ-011 SHALL have port occupancy  output  clog2(DEPTH+1)  count of valid entries held.

Function
REQ-012 Each stage SHALL hold one entry: valid bit, wdata, wd, wreg.
REQ-013 A transfer SHALL occur on an edge when mem_valid and mem_ready are both 1 (input) or wb_valid and wb_ready are both 1 (output).
REQ-014 Stage k SHALL advance when stage k+1 is empty or stage k+1 advances in the same cycle; the last stage advances when wb_ready=1.
REQ-015 mem_ready SHALL be 1 when stage 0 is empty or stage 0 advances, and 0 while flush=1.
REQ-016 Entries SHALL compress forward past empty stages (no bubbles held behind a free stage), so latency with wb_ready=1 is exactly DEPTH cycles.
REQ-017 Throughput SHALL be one entry per cycle with mem_valid=1 and wb_ready=1 held.
REQ-018 wb_valid SHALL equal the last stage's valid bit; wb_wdata, wb_wd and wb_wreg SHALL be driven from the registered last stage with no combinational path from mem_* inputs.
REQ-019 When the last stage is empty, wb_wdata SHALL be all-zero, wb_wd the NOP register address, and wb_wreg write-disable.
REQ-020 wb_wreg SHALL be 1 only when wb_valid=1 and the held wreg=1.
REQ-021 While wb_valid=1 and wb_ready=0, all wb_* outputs SHALL remain stable.
REQ-022 flush=1 SHALL clear every valid bit on the next edge, take priority over simultaneous input or output transfers, and accept no input that cycle.
REQ-023 occupancy SHALL be a registered counter: +1 on input transfer, -1 on output transfer, unchanged on both, 0 after flush; it SHALL never exceed DEPTH.
REQ-024 At occupancy=DEPTH with wb_ready=0, mem_ready SHALL be 0; with wb_ready=1, simultaneous input and output transfers SHALL be accepted.

Reset
REQ-025 rst=0 SHALL immediately clear all valid bits, set occupancy to 0, wb_wdata to zero, wb_wd to the NOP address, and wb_wreg to write-disable.
REQ-026 rst asserted mid-transfer SHALL drop all in-flight entries; the first edge after release SHALL accept input.

Configuration
REQ-027 With macro MEM_WB_HILO_EN defined, the block SHALL add inputs mem_hi, mem_lo (DATA_W each) and mem_whilo (1), and outputs wb_hi, wb_lo and wb_whilo, carried through every stage with the same timing, flush and empty/reset values (zero data, write-disable) as the register path.
REQ-028 Without MEM_WB_HILO_EN, these ports and their storage SHALL not exist.

Structure
REQ-029 The zero-word, NOP-register-address, write-enable/disable and reset-active-low constants SHALL come from the shared define include; no local literals.
REQ-030 One stage SHALL be implemented as sub-module mem_wb_stage and instantiated DEPTH times in a generate loop.

Verification
REQ-031 DEPTH=1, reset then mem_valid=1, wdata=0x12345678, wd=5, wreg=1, wb_ready=1 -> next cycle wb_valid=1, wb_wdata=0x12345678, wb_wd=5, wb_wreg=1.
REQ-032 DEPTH=3, stream 10 entries with wb_ready=1 -> each entry appears exactly 3 cycles after acceptance, in order, with occupancy=3 in steady state.
REQ-033 DEPTH=2, wb_ready=0, push 3 entries -> 2 accepted, mem_ready=0, occupancy=2; raise wb_ready -> entries drain in order and mem_ready returns to 1.
REQ-034 DEPTH=4 full, flush=1 with mem_valid=1 -> next cycle occupancy=0, wb_valid=0, wb_wreg=0, wb_wdata=0, input not accepted.
REQ-035 Assert rst=0 mid-stream between edges -> outputs reset immediately; with MEM_WB_HILO_EN defined, wb_whilo=0 and wb_hi=wb_lo=0.
